// File: rtl/riscv_core_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_issue_ctrl_pkg
// Purpose  : Shared constants and types for the dual-issue controller:
//            instruction function classes, FSM states, steering encoding.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_core_issue_ctrl_pkg;

  // Instruction function classes carried with each issue-latch slot
  localparam logic [1:0] FUNC_ALU    = 2'b00;
  localparam logic [1:0] FUNC_MEM    = 2'b01;
  localparam logic [1:0] FUNC_MULDIV = 2'b10;

  // Steering: 0 puts ir0 on pipe A (ir1 on B), 1 swaps them
  localparam logic STEER_IR0_A = 1'b0;
  localparam logic STEER_IR0_B = 1'b1;

  // Issue FSM: PAIR = both slots pending, IR1_ONLY = ir0 already gone
  typedef enum logic [0:0] {
    ST_PAIR     = 1'b0,
    ST_IR1_ONLY = 1'b1
  } issue_state_e;

  // Pipe B only executes ALU ops, so "is ALU" drives all steering decisions
  function automatic logic is_alu(input logic [1:0] func);
    return (func == FUNC_ALU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_core_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_issue_ctrl_if
// Purpose  : Bundle of issue-latch, scoreboard, pipeline and ROB signals
//            exchanged with the issue controller.
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_core_issue_ctrl_if #(
  parameter int ROB_AW = 4
);
  // Issue latch contents
  logic              inst_val_Ihl;
  logic [4:0]        dst0;
  logic              dst0_en;
  logic [1:0]        func_ir0;
  logic [4:0]        src10;
  logic              src10_en;
  logic [4:0]        src11;
  logic              src11_en;
  logic [4:0]        dst1;
  logic              dst1_en;
  logic [1:0]        func_ir1;
  // Scoreboard / pipeline / ROB status
  logic              stall_ir0;
  logic              stall_ir1;
  logic              stall_X0hl;
  logic              rob_commit_wen_1;
  logic              rob_commit_wen_2;
  logic              rob_flush;
  // Controller results
  logic              ir0_issued;
  logic              ir1_issued;
  logic              steer_signal;
  logic [ROB_AW-1:0] rob_slot0;
  logic [ROB_AW-1:0] rob_slot1;
  logic              stall_Ihl;
  logic [ROB_AW:0]   rob_count;

  // Frontend / environment side
  modport master (
    output inst_val_Ihl, dst0, dst0_en, func_ir0,
           src10, src10_en, src11, src11_en, dst1, dst1_en, func_ir1,
           stall_ir0, stall_ir1, stall_X0hl,
           rob_commit_wen_1, rob_commit_wen_2, rob_flush,
    input  ir0_issued, ir1_issued, steer_signal,
           rob_slot0, rob_slot1, stall_Ihl, rob_count
  );

  // Issue controller side
  modport slave (
    input  inst_val_Ihl, dst0, dst0_en, func_ir0,
           src10, src10_en, src11, src11_en, dst1, dst1_en, func_ir1,
           stall_ir0, stall_ir1, stall_X0hl,
           rob_commit_wen_1, rob_commit_wen_2, rob_flush,
    output ir0_issued, ir1_issued, steer_signal,
           rob_slot0, rob_slot1, stall_Ihl, rob_count
  );
endinterface
`default_nettype wire

// File: rtl/riscv_core_rob_alloc.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_rob_alloc
// Purpose  : ROB tail pointer and occupancy tracking; allocation from issue,
//            release from two commit ports, free-space checks.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_rob_alloc #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic [1:0]        i_alloc_cnt,
  input  logic              i_commit_wen_1,
  input  logic              i_commit_wen_2,
  output logic [ROB_AW-1:0] o_tail,
  output logic [ROB_AW:0]   o_count,
  output logic              o_free_ge1,
  output logic              o_free_ge2
);
  localparam logic [ROB_AW:0] C_CNT_MAX1 = (ROB_AW+1)'(ROB_DEPTH - 1);
  localparam logic [ROB_AW:0] C_CNT_MAX2 = (ROB_AW+1)'(ROB_DEPTH - 2);
  localparam logic [ROB_AW:0] C_CNT_ONE  = (ROB_AW+1)'(1);

  logic [ROB_AW-1:0] r_tail;
  logic [ROB_AW:0]   r_count;
  logic [1:0]        w_commit_req;
  logic [1:0]        w_commit_eff;

  // Clamp commits so occupancy can never underflow
  always_comb begin
    w_commit_req = {1'b0, i_commit_wen_1} + {1'b0, i_commit_wen_2};
    w_commit_eff = w_commit_req;
    if (r_count == '0) begin
      w_commit_eff = 2'd0;
    end else if ((r_count == C_CNT_ONE) && (w_commit_req == 2'd2)) begin
      w_commit_eff = 2'd1;
    end
  end

  // Tail wraps naturally because ROB_DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + ROB_AW'(i_alloc_cnt);
      r_count <= r_count + (ROB_AW+1)'(i_alloc_cnt) - (ROB_AW+1)'(w_commit_eff);
    end
  end

  assign o_tail     = r_tail;
  assign o_count    = r_count;
  assign o_free_ge1 = (r_count <= C_CNT_MAX1);
  assign o_free_ge2 = (r_count <= C_CNT_MAX2);

endmodule
`default_nettype wire

// File: rtl/riscv_core_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_issue_ctrl
// Purpose  : Dual-issue in-order issue controller. Decides which of ir0/ir1
//            issue each cycle, steers them onto pipes A/B and allocates ROB
//            slots.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_issue_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_AW    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  riscv_core_issue_ctrl_if.slave      ictl
);
  import riscv_core_issue_ctrl_pkg::*;

  issue_state_e      r_state;
  issue_state_e      w_state_next;
  logic              w_gate;
  logic              w_raw;
  logic              w_waw;
  logic              w_both_nonalu;
  logic              w_ir0_go;
  logic              w_ir1_go;
  logic              w_steer;
  logic              w_stall;
  logic [1:0]        w_alloc_cnt;
  logic [ROB_AW-1:0] w_tail;
  logic [ROB_AW:0]   w_count;
  logic              w_free_ge1;
  logic              w_free_ge2;

  // Issue FSM state register; flush snaps back to a fresh pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_PAIR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Issue decision, steering, latch stall and next state
  always_comb begin
    w_gate        = ictl.inst_val_Ihl && !ictl.stall_X0hl && !ictl.rob_flush;
    // Writes to x0 never create a dependency
    w_raw         = ictl.dst0_en && (ictl.dst0 != 5'd0) &&
                    ((ictl.src10_en && (ictl.src10 == ictl.dst0)) ||
                     (ictl.src11_en && (ictl.src11 == ictl.dst0)));
    w_waw         = ictl.dst0_en && ictl.dst1_en && (ictl.dst0 == ictl.dst1);
    // Only pipe A handles mem/muldiv, so two of them cannot pair
    w_both_nonalu = !is_alu(ictl.func_ir0) && !is_alu(ictl.func_ir1);
    w_ir0_go      = 1'b0;
    w_ir1_go      = 1'b0;
    w_steer       = STEER_IR0_A;
    w_stall       = 1'b1;
    w_state_next  = r_state;

    if (r_state == ST_PAIR) begin
      w_ir0_go = w_gate && !ictl.stall_ir0 && w_free_ge1;
      w_ir1_go = w_ir0_go && !ictl.stall_ir1 && w_free_ge2 &&
                 !w_raw && !w_waw && !w_both_nonalu;
      if (!is_alu(ictl.func_ir0)) begin
        w_steer = STEER_IR0_A;
      end else if (!is_alu(ictl.func_ir1)) begin
        w_steer = STEER_IR0_B;
      end
      w_stall      = !w_ir1_go;
      w_state_next = (w_ir0_go && !w_ir1_go) ? ST_IR1_ONLY : ST_PAIR;
    end else begin
      // ir0 already left; the ROB slot it took is already counted
      w_ir1_go     = w_gate && !ictl.stall_ir1 && w_free_ge1;
      w_steer      = is_alu(ictl.func_ir1) ? STEER_IR0_A : STEER_IR0_B;
      w_stall      = !w_ir1_go;
      w_state_next = w_ir1_go ? ST_PAIR : ST_IR1_ONLY;
    end

    // Squash: the frontend refills the latch, so it must not be held
    if (ictl.rob_flush) begin
      w_stall      = 1'b0;
      w_state_next = ST_PAIR;
    end
  end

  assign w_alloc_cnt = {1'b0, w_ir0_go} + {1'b0, w_ir1_go};

  riscv_core_rob_alloc #(
    .ROB_DEPTH (ROB_DEPTH),
    .ROB_AW    (ROB_AW)
  ) u_rob_alloc (
    .clk            (clk),
    .reset          (reset),
    .i_flush        (ictl.rob_flush),
    .i_alloc_cnt    (w_alloc_cnt),
    .i_commit_wen_1 (ictl.rob_commit_wen_1),
    .i_commit_wen_2 (ictl.rob_commit_wen_2),
    .o_tail         (w_tail),
    .o_count        (w_count),
    .o_free_ge1     (w_free_ge1),
    .o_free_ge2     (w_free_ge2)
  );

  // Outputs are forced quiet while reset is held
  assign ictl.ir0_issued   = reset && w_ir0_go;
  assign ictl.ir1_issued   = reset && w_ir1_go;
  assign ictl.steer_signal = reset && w_steer;
  assign ictl.stall_Ihl    = reset && w_stall;
  assign ictl.rob_slot0    = w_tail;
  assign ictl.rob_slot1    = (r_state == ST_IR1_ONLY) ? w_tail : (w_tail + ROB_AW'(1));
  assign ictl.rob_count    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_issue_ctrl
// Purpose  : Self-checking bench for the dual-issue controller: a vector
//            table of single-cycle pair decisions plus multi-cycle sequences
//            (split issue, ROB fill/wrap, drain, flush, async reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core_issue_ctrl;
  import riscv_core_issue_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_core_issue_ctrl_if #(.ROB_AW(4)) bus ();

  riscv_core_issue_ctrl #(
    .ROB_DEPTH (16),
    .ROB_AW    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ictl  (bus)
  );

  typedef struct {
    logic       i0;
    logic       i1;
    logic       steer;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       stall;
    logic [4:0] cnt;
  } exp_t;

  typedef struct {
    string      name;
    logic       val;
    logic [4:0] d0;  logic d0e; logic [1:0] f0;
    logic [4:0] s10; logic s10e;
    logic [4:0] s11; logic s11e;
    logic [4:0] d1;  logic d1e; logic [1:0] f1;
    logic       st0; logic st1; logic sx0;
    logic       e_i0; logic e_i1; logic e_steer; logic e_stall;
    logic [4:0] e_cnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input string n, input int val,
                               input int d0, input int d0e, input int f0,
                               input int s10, input int s10e, input int s11, input int s11e,
                               input int d1, input int d1e, input int f1,
                               input int st0, input int st1, input int sx0,
                               input int ei0, input int ei1, input int es, input int est,
                               input int ecnt);
    vec_t v;
    v.name = n;        v.val = 1'(val);
    v.d0 = 5'(d0);     v.d0e = 1'(d0e);   v.f0 = 2'(f0);
    v.s10 = 5'(s10);   v.s10e = 1'(s10e);
    v.s11 = 5'(s11);   v.s11e = 1'(s11e);
    v.d1 = 5'(d1);     v.d1e = 1'(d1e);   v.f1 = 2'(f1);
    v.st0 = 1'(st0);   v.st1 = 1'(st1);   v.sx0 = 1'(sx0);
    v.e_i0 = 1'(ei0);  v.e_i1 = 1'(ei1);  v.e_steer = 1'(es); v.e_stall = 1'(est);
    v.e_cnt = 5'(ecnt);
    return v;
  endfunction

  task automatic set_pair(input int d0, input int d0e, input int f0,
                          input int s10, input int s10e, input int s11, input int s11e,
                          input int d1, input int d1e, input int f1);
    bus.dst0 = 5'(d0);   bus.dst0_en = 1'(d0e);   bus.func_ir0 = 2'(f0);
    bus.src10 = 5'(s10); bus.src10_en = 1'(s10e);
    bus.src11 = 5'(s11); bus.src11_en = 1'(s11e);
    bus.dst1 = 5'(d1);   bus.dst1_en = 1'(d1e);   bus.func_ir1 = 2'(f1);
  endtask

  task automatic set_ctl(input int val, input int st0, input int st1, input int sx0,
                         input int c1, input int c2, input int fl);
    bus.inst_val_Ihl = 1'(val);
    bus.stall_ir0 = 1'(st0); bus.stall_ir1 = 1'(st1); bus.stall_X0hl = 1'(sx0);
    bus.rob_commit_wen_1 = 1'(c1); bus.rob_commit_wen_2 = 1'(c2);
    bus.rob_flush = 1'(fl);
  endtask

  // Push expectation, compare on the falling edge, then step past the next rising edge
  task automatic cycle_check(input string tag, input int i0, input int i1, input int st,
                             input int s0, input int s1, input int stall, input int cnt);
    exp_t e;
    exp_t g;
    e.i0 = 1'(i0); e.i1 = 1'(i1); e.steer = 1'(st);
    e.s0 = 4'(s0); e.s1 = 4'(s1); e.stall = 1'(stall); e.cnt = 5'(cnt);
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    chk({tag, ".ir0_issued"},   32'(bus.ir0_issued),   32'(g.i0));
    chk({tag, ".ir1_issued"},   32'(bus.ir1_issued),   32'(g.i1));
    chk({tag, ".steer"},        32'(bus.steer_signal), 32'(g.steer));
    chk({tag, ".stall_Ihl"},    32'(bus.stall_Ihl),    32'(g.stall));
    chk({tag, ".rob_count"},    32'(bus.rob_count),    32'(g.cnt));
    if (g.i0) chk({tag, ".rob_slot0"}, 32'(bus.rob_slot0), 32'(g.s0));
    if (g.i1) chk({tag, ".rob_slot1"}, 32'(bus.rob_slot1), 32'(g.s1));
    @(posedge clk);
    #1;
  endtask

  // One flush cycle: checks quiet outputs and the occupancy left by the previous cycle
  task automatic flush_check(input string tag, input int cnt);
    bus.rob_flush = 1'b1;
    @(negedge clk);
    chk({tag, ".flush_ir0"},   32'(bus.ir0_issued), 32'd0);
    chk({tag, ".flush_ir1"},   32'(bus.ir1_issued), 32'd0);
    chk({tag, ".flush_stall"}, 32'(bus.stall_Ihl),  32'd0);
    chk({tag, ".count_after"}, 32'(bus.rob_count),  32'(cnt));
    @(posedge clk);
    #1;
    bus.rob_flush = 1'b0;
  endtask

  initial begin
    // name val d0 d0e f0 s10 s10e s11 s11e d1 d1e f1 st0 st1 sx0 | i0 i1 steer stall cnt_after
    vecs[0]  = mkv("alu_pair",   1, 3,1,0, 1,1, 2,1, 4,1,0, 0,0,0, 1,1,0,0, 2);
    vecs[1]  = mkv("alu_mem",    1, 3,1,0, 1,1, 2,1, 4,1,1, 0,0,0, 1,1,1,0, 2);
    vecs[2]  = mkv("mem_muldiv", 1, 3,1,1, 1,1, 2,1, 4,1,2, 0,0,0, 1,0,0,1, 1);
    vecs[3]  = mkv("raw_src10",  1, 5,1,0, 5,1, 2,1, 6,1,0, 0,0,0, 1,0,0,1, 1);
    vecs[4]  = mkv("raw_src11",  1, 5,1,0, 1,1, 5,1, 6,1,0, 0,0,0, 1,0,0,1, 1);
    vecs[5]  = mkv("x0_no_raw",  1, 0,1,0, 0,1, 0,1, 4,1,0, 0,0,0, 1,1,0,0, 2);
    vecs[6]  = mkv("waw",        1, 7,1,0, 1,1, 2,1, 7,1,0, 0,0,0, 1,0,0,1, 1);
    vecs[7]  = mkv("waw_dis",    1, 7,1,0, 1,1, 2,1, 7,0,0, 0,0,0, 1,1,0,0, 2);
    vecs[8]  = mkv("stall_ir0",  1, 3,1,0, 1,1, 2,1, 4,1,0, 1,0,0, 0,0,0,1, 0);
    vecs[9]  = mkv("stall_ir1",  1, 3,1,0, 1,1, 2,1, 4,1,0, 0,1,0, 1,0,0,1, 1);
    vecs[10] = mkv("stall_x0",   1, 3,1,0, 1,1, 2,1, 4,1,0, 0,0,1, 0,0,0,1, 0);
    vecs[11] = mkv("not_valid",  0, 3,1,0, 1,1, 2,1, 4,1,0, 0,0,0, 0,0,0,1, 0);
    vecs[12] = mkv("muldiv_alu", 1, 3,1,2, 1,1, 2,1, 4,1,0, 0,0,0, 1,1,0,0, 2);
    vecs[13] = mkv("src_dis",    1, 5,1,0, 5,0, 5,0, 6,1,0, 0,0,0, 1,1,0,0, 2);
    vecs[14] = mkv("alu_md_st1", 1, 3,1,0, 1,1, 2,1, 4,1,2, 0,1,0, 1,0,1,1, 1);

    // Reset held with a live pair that would otherwise steer to 1
    set_pair(3,1,0, 1,1, 2,1, 4,1,1);
    set_ctl(1,0,0,0, 0,0,0);
    repeat (2) @(posedge clk);
    #1;
    cycle_check("reset", 0,0,0, 0,1, 0, 0);
    reset = 1'b1;

    // Table: each vector starts from an empty ROB in PAIR
    for (int i = 0; i < 15; i++) begin
      set_pair(vecs[i].d0, vecs[i].d0e, vecs[i].f0, vecs[i].s10, vecs[i].s10e,
               vecs[i].s11, vecs[i].s11e, vecs[i].d1, vecs[i].d1e, vecs[i].f1);
      set_ctl(vecs[i].val, vecs[i].st0, vecs[i].st1, vecs[i].sx0, 0,0,0);
      cycle_check(vecs[i].name, vecs[i].e_i0, vecs[i].e_i1, vecs[i].e_steer,
                  0, 1, vecs[i].e_stall, 0);
      flush_check(vecs[i].name, vecs[i].e_cnt);
    end

    // Split issue: mem then muldiv over two cycles
    set_pair(3,1,1, 1,1, 2,1, 4,1,2);
    set_ctl(1,0,0,0, 0,0,0);
    cycle_check("split_c1", 1,0,0, 0,0, 1, 0);
    cycle_check("split_c2", 0,1,1, 1,1, 0, 1);
    flush_check("split", 2);

    // RAW split with ir1 held by the scoreboard for three cycles
    set_pair(5,1,0, 5,1, 2,1, 6,1,0);
    set_ctl(1,0,1,0, 0,0,0);
    cycle_check("raw_hold_c1", 1,0,0, 0,0, 1, 0);
    cycle_check("raw_hold_c2", 0,0,0, 1,1, 1, 1);
    cycle_check("raw_hold_c3", 0,0,0, 1,1, 1, 1);
    bus.stall_ir1 = 1'b0;
    cycle_check("raw_hold_c4", 0,1,0, 1,1, 0, 1);
    flush_check("raw_hold", 2);

    // Fill ROB with pairs; tail wraps 14/15 -> 0
    set_pair(3,1,0, 1,1, 2,1, 4,1,0);
    set_ctl(1,0,0,0, 0,0,0);
    for (int k = 0; k < 8; k++) begin
      cycle_check($sformatf("fill_%0d", k), 1,1,0, (2*k) % 16, (2*k+1) % 16, 0, 2*k);
    end
    set_ctl(0,0,0,0, 1,0,0);
    cycle_check("full_commit", 0,0,0, 0,1, 1, 16);
    // count 15: ir0 only, a same-cycle commit must not open room for ir1
    set_ctl(1,0,0,0, 1,0,0);
    cycle_check("cnt15_pair", 1,0,0, 0,1, 1, 15);
    set_ctl(1,0,0,0, 0,0,0);
    cycle_check("cnt15_ir1", 0,1,0, 1,1, 0, 15);
    cycle_check("full_block", 0,0,0, 2,3, 1, 16);
    flush_check("full", 16);

    // Drain 4 -> 0 with dual commits, then commits at empty
    set_ctl(1,0,0,0, 0,0,0);
    cycle_check("drain_fill0", 1,1,0, 0,1, 0, 0);
    cycle_check("drain_fill1", 1,1,0, 2,3, 0, 2);
    set_ctl(0,0,0,0, 1,1,0);
    cycle_check("drain_c1", 0,0,0, 4,5, 1, 4);
    cycle_check("drain_c2", 0,0,0, 4,5, 1, 2);
    cycle_check("drain_c3", 0,0,0, 4,5, 1, 0);
    cycle_check("drain_c4", 0,0,0, 4,5, 1, 0);
    flush_check("drain", 0);

    // Flush while in IR1_ONLY, then confirm a fresh PAIR at tail 0
    set_pair(5,1,0, 5,1, 2,1, 6,1,0);
    set_ctl(1,0,0,0, 0,0,0);
    cycle_check("fl_c1", 1,0,0, 0,0, 1, 0);
    bus.rob_flush = 1'b1;
    cycle_check("fl_c2", 0,0,0, 1,1, 0, 1);
    bus.rob_flush = 1'b0;
    cycle_check("fl_c3", 1,0,0, 0,0, 1, 0);

    // Async reset mid-operation (now IR1_ONLY, ir1 mem ready to issue)
    set_pair(5,1,0, 5,1, 2,1, 6,1,1);
    #1;
    chk("pre_rst.ir1_issued", 32'(bus.ir1_issued),   32'd1);
    chk("pre_rst.steer",      32'(bus.steer_signal), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst.ir0_issued", 32'(bus.ir0_issued),   32'd0);
    chk("async_rst.ir1_issued", 32'(bus.ir1_issued),   32'd0);
    chk("async_rst.steer",      32'(bus.steer_signal), 32'd0);
    chk("async_rst.stall_Ihl",  32'(bus.stall_Ihl),    32'd0);
    chk("async_rst.rob_count",  32'(bus.rob_count),    32'd0);
    chk("async_rst.rob_slot0",  32'(bus.rob_slot0),    32'd0);
    chk("async_rst.rob_slot1",  32'(bus.rob_slot1),    32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_pair(3,1,0, 1,1, 2,1, 4,1,0);
    cycle_check("post_rst", 1,1,0, 0,1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_core_issue_ctrl.md
Name: riscv_core_issue_ctrl

Overview:
- Dual-issue in-order issue controller between the decode/issue latch (ir0 older, ir1 younger) and pipelines A/B.
- Each cycle it decides which of ir0/ir1 issue and drives steer_signal; these feed the scoreboard's issue and steer inputs.
- It consumes the scoreboard stalls (stall_ir0/stall_ir1) and resolves intra-pair hazards and pipeline structural limits.
- It allocates reorder-buffer slots and tracks ROB occupancy against the commit ports.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; power of two, 4..32.
- ROB_AW, 4, log2(ROB_DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- inst_val_Ihl  in  1  issue latch holds a valid pair
- dst0 / dst0_en / func_ir0  in  5/1/2  ir0 destination, write enable, type (00 alu, 01 mem, 10 muldiv)
- src10 / src10_en / src11 / src11_en  in  5/1/5/1  ir1 sources
- dst1 / dst1_en / func_ir1  in  5/1/2  ir1 destination, write enable, type
- stall_ir0 / stall_ir1  in  1/1  scoreboard operand stalls
- stall_X0hl  in  1  X0 stage of both pipelines stalled
- rob_commit_wen_1 / rob_commit_wen_2  in  1/1  ROB commit ports (each frees one slot)
- rob_flush  in  1  squash: empty ROB, drop partial pair
- ir0_issued / ir1_issued  out  1/1  issue strobes
- steer_signal  out  1  0: ir0→A, ir1→B; 1: ir0→B, ir1→A
- rob_slot0 / rob_slot1  out  ROB_AW each  slots allocated to ir0 / ir1 this cycle
- stall_Ihl  out  1  hold the issue latch (pair not fully consumed)
- rob_count  out  ROB_AW+1  current occupancy

Behaviour:
- Pipe A executes all types; pipe B is ALU only.
- States: PAIR (both pending), IR1_ONLY (ir0 already issued, ir1 pending). Reset → PAIR, tail=0, count=0.
- During reset: all issue strobes 0, steer_signal 0, stall_Ihl 0.
- Outputs are combinational from the registered state/pointers; state, tail and count update on posedge clk.
- All issue is gated by inst_val_Ihl && !stall_X0hl && !rob_flush.
- PAIR, ir0 can issue: !stall_ir0 && count<=DEPTH-1.
- PAIR, ir1 can issue with ir0: ir0 issues && !stall_ir1 && count<=DEPTH-2 && no RAW (ir1 srcN_en && srcN==dst0 && dst0_en && dst0!=0) && no WAW (dst0==dst1, both enabled) && not (both types non-alu).
- Steering in PAIR: ir0 non-alu → steer=0. Else ir1 non-alu → steer=1. Else steer=0.
- PAIR outcomes:
  - Both issue → stay PAIR, stall_Ihl=0.
  - Only ir0 issues → IR1_ONLY, stall_Ihl=1.
  - Neither issues → stall_Ihl=1.
- IR1_ONLY:
  - ir0_issued=0.
  - ir1 issues if !stall_ir1 && count<=DEPTH-1.
  - steer=1 if ir1 non-alu, else 0.
  - On issue → PAIR, stall_Ihl=0. Else stay, stall_Ihl=1.
  - ir1 never issues before ir0 (in-order).
- ROB allocation:
  - rob_slot0=tail. rob_slot1 = tail+1 when both issue; in IR1_ONLY rob_slot1=tail.
  - tail advances by the number issued, mod ROB_DEPTH (wraps DEPTH-1→0).
  - count_next = count + issued − commits, where commits = wen_1+wen_2.
  - Commits with count 0 are ignored, and commits never exceed count.
  - A same-cycle commit does not enable issue; fullness uses the registered count.
- rob_flush (highest priority, synchronous):
  - Next state PAIR, tail=0, count=0.
  - No issue that cycle; stall_Ihl=0 (latch refilled by frontend).
- Reset asserted mid-operation: immediate asynchronous return to reset values.

Decomposition:
- Shared package: func-type constants (alu/mem/muldiv), state encoding, steer constants (STEER_IR0_A=0).
- Sub-module riscv_core_rob_alloc holds tail/count, alloc/commit arithmetic and the full checks (free>=1, free>=2).

Test Plan:
- Two independent ALU ops (dst 3, dst 4), count 0 → both issue same cycle, steer 0, slots 0/1, count 2.
- ir0 ALU, ir1 mem → both issue, steer 1; ir0 mem, ir1 muldiv → ir0 issues (steer 0), next cycle ir1 issues (steer 1), stall_Ihl 1 then 0.
- ir0 writes x5, ir1 reads x5 → ir0 only, IR1_ONLY; with stall_ir1 held 3 cycles, ir1 issues in cycle 4.
- Fill ROB to 15 with DEPTH 16 → pair issues ir0 only (slot 15, tail wraps to 0); a commit the same cycle does not enable ir1.
- Two commits per cycle drain count 4→0 in 2 cycles; extra commits at 0 leave count 0.
- rob_flush in IR1_ONLY → PAIR, tail 0, count 0, no strobes; async reset mid-pair clears all outputs immediately.
